// File: rtl/gray_share_arbiter_if.sv
// Bundle of requester and result handshake signals for gray_share_arbiter.
// Under GRAY_DECODE_EN the bundle also carries the per-requester direction select req_dir.
interface gray_share_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = $clog2(NREQ)
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [IDW-1:0]        out_id;
    logic                  out_ready;
    logic                  busy;
`ifdef GRAY_DECODE_EN
    logic [NREQ-1:0]       req_dir;
`endif

    // The arbiter is the slave; requesters plus the result consumer form the master side.
    modport slave (
`ifdef GRAY_DECODE_EN
        input  req_dir,
`endif
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id, busy
    );

    modport master (
`ifdef GRAY_DECODE_EN
        output req_dir,
`endif
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id, busy
    );
endinterface

// File: rtl/gray_share_arbiter.sv
// Round-robin arbiter sharing one binary-to-Gray converter among NREQ requesters.
// Define GRAY_DECODE_EN to add per-requester Gray-to-binary conversion selected by req_dir.
module gray_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gray_share_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

    state_t           state_q;
    logic [IDW-1:0]   ptr_q;
    logic [WIDTH-1:0] data_q;
    logic [IDW-1:0]   id_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [IDW-1:0]   out_id_q;
`ifdef GRAY_DECODE_EN
    logic             dir_q;
`endif

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   win_id;
    logic [IDW-1:0]   idx;
    logic             found;
    logic [WIDTH-1:0] win_data;
    logic [WIDTH-1:0] conv_d;
    logic [IDW-1:0]   ptr_d;
    logic             take;

    function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [WIDTH-1:0] to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] r;
        r[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            r[i] = r[i+1] ^ g[i];
        end
        return r;
    endfunction

    // Grant search starts at ptr and wraps; held low during reset so outputs read all-zero.
    always_comb begin
        grant  = '0;
        win_id = '0;
        idx    = '0;
        found  = 1'b0;
        if (state_q == IDLE && rst_n) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = IDW'((int'(ptr_q) + k) % NREQ);
                if (!found && bus.req_valid[idx]) begin
                    found  = 1'b1;
                    win_id = idx;
                end
            end
            if (found) begin
                grant[win_id] = 1'b1;
            end
        end
    end

    assign take     = |(grant & bus.req_valid);
    assign win_data = bus.req_data[win_id*WIDTH +: WIDTH];
    assign ptr_d    = (int'(id_q) == NREQ - 1) ? '0 : id_q + 1'b1;

`ifdef GRAY_DECODE_EN
    assign conv_d = dir_q ? to_bin(data_q) : to_gray(data_q);
`else
    assign conv_d = to_gray(data_q);
`endif

    // The pointer moves only when a result is consumed, so a grant alone never rotates priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            data_q      <= '0;
            id_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
`ifdef GRAY_DECODE_EN
            dir_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (take) begin
                        data_q  <= win_data;
                        id_q    <= win_id;
`ifdef GRAY_DECODE_EN
                        dir_q   <= bus.req_dir[win_id];
`endif
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    out_data_q  <= conv_d;
                    out_id_q    <= id_q;
                    out_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        ptr_q       <= ptr_d;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = grant;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_gray_share_arbiter.sv
// Randomised directed bench for gray_share_arbiter against a behavioural arbitration/conversion model.
// Build with GRAY_DECODE_EN defined to also exercise the Gray-to-binary direction.
module tb_gray_share_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int IDW   = 2;
    localparam int DW    = NREQ * WIDTH;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gray_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

    gray_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int cycleCount = 0;
    int modelPtr = 0;
    int lastGrantCycle = 0;
    logic [WIDTH-1:0] lastOutData;
    logic [NREQ-1:0] dirSel = '0;

`ifdef GRAY_DECODE_EN
    assign bus.req_dir = dirSel;
`endif

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Gray code by definition: top bit copied, every other bit is the XOR of itself and its upper neighbour.
    function automatic logic [WIDTH-1:0] refGray(input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] g;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == WIDTH - 1) g[i] = b[i];
            else                g[i] = b[i+1] ^ b[i];
        end
        return g;
    endfunction

    // Binary bit i is the parity of all Gray bits at or above position i.
    function automatic logic [WIDTH-1:0] refBin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        for (int i = 0; i < WIDTH; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    function automatic int refWinner(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
            $error("[TB] check %s did not match", tag);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] valid, input logic [DW-1:0] data, input logic outReady);
        bus.req_valid = valid;
        bus.req_data  = data;
        bus.out_ready = outReady;
    endtask

    // One complete transaction starting and ending on a falling clock edge.
    task automatic runTxn(input logic [NREQ-1:0] valid, input logic [DW-1:0] data, input int holdCycles, input string tag);
        int w;
        logic [WIDTH-1:0] word;
        logic [WIDTH-1:0] expData;
        applyStimulus(valid, data, holdCycles == 0);
        #1;
        w = refWinner(valid, modelPtr);
        checkOutput({tag, ".grant"}, 32'(bus.req_ready), 32'(1) << w);
        checkOutput({tag, ".idleBusy"}, 32'(bus.busy), 32'(0));
        lastGrantCycle = cycleCount;
        word = data[w*WIDTH +: WIDTH];
        expData = refGray(word);
`ifdef GRAY_DECODE_EN
        if (dirSel[w]) expData = refBin(word);
`endif
        @(negedge clk);
        checkOutput({tag, ".convBusy"}, 32'(bus.busy), 32'(1));
        checkOutput({tag, ".convValid"}, 32'(bus.out_valid), 32'(0));
        checkOutput({tag, ".convReady"}, 32'(bus.req_ready), 32'(0));
        bus.req_data = DW'($urandom);
        @(negedge clk);
        checkOutput({tag, ".outValid"}, 32'(bus.out_valid), 32'(1));
        checkOutput({tag, ".outData"}, 32'(bus.out_data), 32'(expData));
        checkOutput({tag, ".outId"}, 32'(bus.out_id), 32'(w));
        lastOutData = bus.out_data;
        for (int h = 0; h < holdCycles; h++) begin
            @(negedge clk);
            checkOutput({tag, ".holdValid"}, 32'(bus.out_valid), 32'(1));
            checkOutput({tag, ".holdData"}, 32'(bus.out_data), 32'(expData));
            checkOutput({tag, ".holdId"}, 32'(bus.out_id), 32'(w));
            checkOutput({tag, ".holdReady"}, 32'(bus.req_ready), 32'(0));
            checkOutput({tag, ".holdBusy"}, 32'(bus.busy), 32'(1));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checkOutput({tag, ".doneValid"}, 32'(bus.out_valid), 32'(0));
        modelPtr = (w + 1) % NREQ;
    endtask

    initial begin
        logic [DW-1:0] data;
        logic [NREQ-1:0] valid;
        int r;
        int prevGrant;

        $display("[TB] start");
        rst_n = 1'b0;
        applyStimulus(NREQ'($urandom_range(1, 15)), DW'($urandom), 1'($urandom));
        repeat (2) @(negedge clk);
        checkOutput("rst.ready", 32'(bus.req_ready), 32'(0));
        checkOutput("rst.valid", 32'(bus.out_valid), 32'(0));
        checkOutput("rst.data", 32'(bus.out_data), 32'(0));
        checkOutput("rst.id", 32'(bus.out_id), 32'(0));
        checkOutput("rst.busy", 32'(bus.busy), 32'(0));

        rst_n = 1'b1;
        applyStimulus('0, DW'($urandom), 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("idle.valid", 32'(bus.out_valid), 32'(0));
            checkOutput("idle.busy", 32'(bus.busy), 32'(0));
            checkOutput("idle.ready", 32'(bus.req_ready), 32'(0));
        end

        data = DW'($urandom);
        data[2*WIDTH +: WIDTH] = 4'b1011;
        runTxn(4'b0100, data, 0, "single");
        checkOutput("single.const", 32'(lastOutData), 32'(4'b1110));

        for (int b = 0; b < 16; b++) begin
            r = $urandom_range(0, NREQ - 1);
            data = DW'($urandom);
            data[r*WIDTH +: WIDTH] = WIDTH'(b);
            runTxn(NREQ'(1) << r, data, 0, "sweep");
        end

        runTxn(4'b1000, DW'($urandom), 6, "bp");

        runTxn(4'b0001, DW'($urandom), 0, "pre");
        applyStimulus(4'b0100, DW'($urandom), 1'b0);
        #1;
        checkOutput("abort.grant", 32'(bus.req_ready), 32'(4'b0100));
        repeat (2) @(negedge clk);
        checkOutput("abort.holdValid", 32'(bus.out_valid), 32'(1));
        rst_n = 1'b0;
        #1;
        checkOutput("abort.valid", 32'(bus.out_valid), 32'(0));
        checkOutput("abort.busy", 32'(bus.busy), 32'(0));
        checkOutput("abort.data", 32'(bus.out_data), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid = '0;
        modelPtr = 0;
        repeat (2) begin
            @(negedge clk);
            checkOutput("abort.noReplay", 32'(bus.out_valid), 32'(0));
            checkOutput("abort.idle", 32'(bus.busy), 32'(0));
        end

        prevGrant = 0;
        for (int i = 0; i < 8; i++) begin
            runTxn(4'b1111, DW'($urandom), 0, "rr");
            checkOutput("rr.order", 32'(bus.out_id), 32'(i % NREQ));
            if (i > 0) checkOutput("rr.period", 32'(lastGrantCycle - prevGrant), 32'(3));
            prevGrant = lastGrantCycle;
        end

        for (int i = 0; i < 20; i++) begin
            valid = NREQ'($urandom_range(1, 15));
`ifdef GRAY_DECODE_EN
            dirSel = NREQ'($urandom);
`endif
            runTxn(valid, DW'($urandom), $urandom_range(0, 2), "rand");
        end

`ifdef GRAY_DECODE_EN
        dirSel = 4'b0010;
        data = DW'($urandom);
        data[1*WIDTH +: WIDTH] = 4'b1110;
        runTxn(4'b0010, data, 0, "dec1");
        checkOutput("dec1.const", 32'(lastOutData), 32'(4'b1011));
        dirSel = 4'b0000;
        runTxn(4'b0010, data, 0, "dec0");
        checkOutput("dec0.const", 32'(lastOutData), 32'(4'b1001));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gray_share_arbiter.md
# gray_share_arbiter

Shares one WIDTH-bit binary-to-Gray conversion datapath among NREQ requesters. It arbitrates round-robin between the requesters, captures the granted word and converts it in a dedicated cycle. The registered result is presented with the winner's ID on a valid/ready output port. It sits between the lab's input sources (switch/counter front-ends) and the display or checker logic that consumes Gray codes.

## Interface
- NREQ, 4, number of requesters; 2 to 8.
- WIDTH, 4, data width in bits; 2 to 16.
- IDW, $clog2(NREQ), width of the requester ID.
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- req_valid  input  NREQ  bit i: requester i has a word pending.
- req_data  input  NREQ*WIDTH  requester i's binary word is in bits [i*WIDTH +: WIDTH].
- req_ready  output  NREQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high at a clock edge.
- out_valid  output  1  out_data and out_id hold a converted result.
- out_data  output  WIDTH  converted code.
- out_id  output  IDW  index of the requester that produced out_data.
- out_ready  input  1  consumer accepts the result.
- busy  output  1  high whenever the state is not IDLE.

## Operation
- There are three states: IDLE, CONV and HOLD.
- IDLE:
  - The grant is computed combinationally from req_valid and the round-robin pointer ptr.
  - Search order is ptr, ptr+1, …, wrapping modulo NREQ. The first requester found with req_valid high wins.
  - req_ready is one-hot on the winner and all-zero otherwise.
  - When a transfer occurs, the winner's data goes into data_q and its index into id_q, and the state moves to CONV.
  - With no request pending, the state stays IDLE.
- CONV:
  - out_data <= data_q ^ (data_q >> 1), which is the bitwise Gray conversion: g[W-1]=b[W-1], g[i]=b[i+1]^b[i].
  - out_id <= id_q, out_valid <= 1, and the state moves to HOLD.
  - req_ready is all-zero.
- HOLD:
  - out_valid, out_data and out_id stay stable until out_ready is sampled high.
  - On the out_valid & out_ready edge: out_valid <= 0, ptr <= (id_q+1) mod NREQ, and the state moves to IDLE.
  - req_ready is all-zero.
- ptr advances only on output completion, never on a grant alone. A requester that stays asserted cannot be granted twice in a row while another requester is pending.
- Fairness: with all NREQ requesters continuously valid, grants rotate 0,1,…,NREQ-1,0,…
- req_valid dropping in IDLE before a grant is legal; it is simply not selected.
- A requester may change req_data while it is not granted; data is sampled only on the transfer edge.
- Reset values: state=IDLE, ptr=0, out_valid=0, out_data=0, out_id=0, data_q=0, id_q=0, req_ready=0, busy=0.
- Reset asserted mid-operation (CONV or HOLD) aborts the transaction immediately. The pending result is discarded and not replayed after reset.

## Timing
- A request accepted at edge T produces out_valid high after edge T+1.
- The earliest next grant is the cycle after output completion. Minimum period is 3 cycles per word with out_ready tied high.
- req_ready and busy are combinational from state, ptr and req_valid. They have no combinational path from out_ready.
- out_* are registered outputs with no combinational path from any input.
- If out_ready is high in HOLD, completion happens at the next edge. Back-to-back operation is therefore IDLE→CONV→HOLD→IDLE.

## Configuration
- The macro GRAY_DECODE_EN selects whether the inverse (Gray-to-binary) conversion is built in.
- Defined:
  - An extra input req_dir, NREQ bits wide, selects the direction per requester: 0 = binary→Gray, 1 = Gray→binary.
  - req_dir[i] is sampled with the data at the transfer edge.
  - When the sampled direction is 1, CONV computes b[W-1]=g[W-1] and b[i]=b[i+1]^g[i] for i from W-2 down to 0. This is a single-cycle combinational prefix XOR.
- Undefined: the req_dir port does not exist, and only binary→Gray is built.
- Timing and arbitration are identical in both builds.

## Test plan
- Reset check: assert rst_n=0 with arbitrary inputs. All outputs must be 0 and busy=0. Release rst_n, keep req_valid=0 for 5 cycles, and confirm nothing changes.
- Single request: NREQ=4, WIDTH=4, req_valid=4'b0100, data for requester 2 = 4'b1011.
  - Required: req_ready=4'b0100 at the transfer.
  - Required: out_valid high 2 edges later with out_data=4'b1110 and out_id=2.
- Sweep: for each binary value 0–15, expect out_data = b^(b>>1); for example 7→4'b0100 and 15→4'b1000.
- Round-robin: hold all four req_valid high with out_ready=1.
  - Required grant order over 8 transactions: 0,1,2,3,0,1,2,3.
  - Required: one result every 3 cycles.
- Backpressure and abort:
  - Hold out_ready=0 for 6 cycles in HOLD. out_* must be stable, req_ready=0 and busy=1.
  - Assert rst_n=0 during HOLD. out_valid must drop immediately, and after release the state is IDLE with ptr=0.
- GRAY_DECODE_EN build: req_dir[1]=1 with data 4'b1110 must give out_data=4'b1011. req_dir[1]=0 with the same data must give 4'b1001.
